// File: rtl/interfaccia_parallela_ingresso_fifo.sv
// Buffered parallel input interface: the device pushes words into a DEPTH-entry FIFO
// through a dav_/rfd handshake, and the CPU reads RBR (FIFO head) or STR (status)
// over a tri-state bus.
module interfaccia_parallela_ingresso_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         s_,
  input  logic         ior_,
  input  logic         a0,
  output logic [W-1:0] d,
  input  logic [W-1:0] byte_in,
  input  logic         dav_,
  output logic         rfd,
  output logic         intr
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {H_IDLE, H_WAIT} hs_t;

  hs_t             r_state, w_state_nx;
  logic            r_rfd, w_rfd_nx;
  logic            r_dav_s1, r_dav_s2;
  logic            r_e_s1, r_e_s2, r_e_d;
  logic [CW-1:0]   r_count, w_count_nx;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [W-1:0]    r_mem [DEPTH];
  logic [W-1:0]    r_out;
  logic            r_rsel, r_rvalid;
  logic            r_intr;
  logic            w_e, w_push, w_pop, w_end;
  logic            w_not_empty, w_full;
  logic [W-1:0]    w_str, w_rbr;

  assign w_e         = ~(s_ | ior_);
  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == CW'(DEPTH));
  // A push is only possible in H_IDLE while rfd is asserted; rfd is never high at full.
  assign w_push      = (r_state == H_IDLE) & ~r_dav_s2 & r_rfd;
  // A read ends when the synchronised enable falls; only a non-empty RBR read pops.
  assign w_end       = ~r_e_s2 & r_e_d;
  assign w_pop       = w_end & ~r_rsel & r_rvalid;
  assign w_rbr       = w_not_empty ? r_mem[r_rd_ptr] : '0;

  assign d    = w_e ? r_out : {W{1'bz}};
  assign rfd  = r_rfd;
  assign intr = r_intr;

  // Status word: not_empty, full, then the occupancy count; upper bits zero.
  always_comb begin
    w_str            = '0;
    w_str[0]         = w_not_empty;
    w_str[1]         = w_full;
    w_str[CW+1:2]    = r_count;
  end

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_nx = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + 1'b1;
      2'b01:   w_count_nx = r_count - 1'b1;
      default: w_count_nx = r_count;
    endcase
  end

  // Handshake FSM next state and next rfd.
  always_comb begin
    w_state_nx = r_state;
    w_rfd_nx   = r_rfd;
    case (r_state)
      H_IDLE: begin
        w_rfd_nx = (w_count_nx < CW'(DEPTH));
        if (w_push) begin
          w_rfd_nx   = 1'b0;
          w_state_nx = H_WAIT;
        end
      end
      H_WAIT: begin
        w_rfd_nx = 1'b0;
        if (r_dav_s2) begin
          w_rfd_nx   = (w_count_nx < CW'(DEPTH));
          w_state_nx = H_IDLE;
        end
      end
      default: begin
        w_rfd_nx   = 1'b0;
        w_state_nx = H_IDLE;
      end
    endcase
  end

  // Control state: synchronisers (dav_ idles high), FSM, pointers, count, read capture.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_dav_s1 <= 1'b1;
      r_dav_s2 <= 1'b1;
      r_e_s1   <= 1'b0;
      r_e_s2   <= 1'b0;
      r_e_d    <= 1'b0;
      r_state  <= H_IDLE;
      r_rfd    <= 1'b0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_intr   <= 1'b0;
      r_out    <= '0;
      r_rsel   <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_dav_s1 <= dav_;
      r_dav_s2 <= r_dav_s1;
      r_e_s1   <= w_e;
      r_e_s2   <= r_e_s1;
      r_e_d    <= r_e_s2;
      r_state  <= w_state_nx;
      r_rfd    <= w_rfd_nx;
      r_count  <= w_count_nx;
      r_intr   <= (w_count_nx != '0);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // The last load before e_s rises captures data, select and validity together,
      // so a push landing mid-read cannot turn an empty read into a pop.
      if (!r_e_s2) begin
        r_out    <= a0 ? w_str : w_rbr;
        r_rsel   <= a0;
        r_rvalid <= w_not_empty;
      end
    end
  end

  // FIFO storage, written at the tail on each accepted push.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= byte_in;
  end
endmodule

// File: tb/tb_interfaccia_parallela_ingresso_fifo.sv
// Scoreboard bench: read tasks queue the expected bus value, a monitor samples d
// once the read has settled and compares it against the queue head.
module tb_interfaccia_parallela_ingresso_fifo;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_;
  logic [1:0]  s_n, ior_n, a0v, dav_n;
  logic [7:0]  bin0;
  logic [15:0] bin1;
  wire  [7:0]  d0;
  wire  [15:0] d1;
  logic        rfd0, intr0, rfd1, intr1;

  interfaccia_parallela_ingresso_fifo #(.W(8), .DEPTH(4)) u_dut (
    .clock(clock), .reset_(reset_), .s_(s_n[0]), .ior_(ior_n[0]), .a0(a0v[0]),
    .d(d0), .byte_in(bin0), .dav_(dav_n[0]), .rfd(rfd0), .intr(intr0));

  interfaccia_parallela_ingresso_fifo #(.W(16), .DEPTH(8)) u_dut16 (
    .clock(clock), .reset_(reset_), .s_(s_n[1]), .ior_(ior_n[1]), .a0(a0v[1]),
    .d(d1), .byte_in(bin1), .dav_(dav_n[1]), .rfd(rfd1), .intr(intr1));

  typedef struct { int u; logic [15:0] val; } exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0;
  int c0 = 0, c1 = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic rfd_of(int u);
    return (u == 0) ? rfd0 : rfd1;
  endfunction

  task automatic score(int u, logic [15:0] act);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_read u%0d got=%h exp=none", u, act);
    end else begin
      e = sbq.pop_front();
      if (e.u != u) begin
        checks++; failures++;
        $display("FAIL read_instance got=%0d exp=%0d", u, e.u);
      end else chk($sformatf("read_u%0d", u), act, e.val);
    end
  endtask

  // Monitor: data is stable from 2 edges after e rises; sample after the 4th.
  always @(negedge clock) begin
    if (!(s_n[0] | ior_n[0])) c0 = c0 + 1; else c0 = 0;
    if (!(s_n[1] | ior_n[1])) c1 = c1 + 1; else c1 = 0;
    if (c0 == 4) score(0, {8'h00, d0});
    if (c1 == 4) score(1, d1);
  end

  // Bus read: ior_ low 5 clocks, then high 4 clocks.
  task automatic rd(int u, logic sel, logic [15:0] exp);
    exp_t e;
    e.u = u; e.val = exp;
    sbq.push_back(e);
    a0v[u] = sel; s_n[u] = 1'b0; ior_n[u] = 1'b0;
    repeat (5) @(posedge clock);
    #1; s_n[u] = 1'b1; ior_n[u] = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  // Device handshake; acc says whether the word must be accepted.
  task automatic wr(int u, logic [15:0] v, bit acc);
    bit fell = 1'b0;
    if (u == 0) bin0 = v[7:0]; else bin1 = v;
    dav_n[u] = 1'b0;
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clock); #1;
        if (!rfd_of(u)) begin fell = 1'b1; break; end
      end
      chk($sformatf("rfd_fall_u%0d", u), {15'b0, fell}, 16'h0001);
    end else begin
      repeat (6) @(posedge clock);
      #1;
      chk($sformatf("rfd_full_u%0d", u), {15'b0, rfd_of(u)}, 16'h0000);
    end
    dav_n[u] = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    reset_ = 1'b0; s_n = '1; ior_n = '1; a0v = '0; dav_n = '1; bin0 = '0; bin1 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rfd", {15'b0, rfd0}, 16'h0);
    chk("rst_intr", {15'b0, intr0}, 16'h0);
    reset_ = 1'b1;
    chk("rfd_before_first_clk", {15'b0, rfd0}, 16'h0);
    @(posedge clock); #1;
    chk("rfd_after_release", {15'b0, rfd0}, 16'h1);
    rd(0, 1'b1, 16'h00);

    // Single word
    wr(0, 16'hA5, 1'b1);
    chk("intr_one", {15'b0, intr0}, 16'h1);
    rd(0, 1'b0, 16'hA5);
    rd(0, 1'b1, 16'h00);
    chk("intr_drained", {15'b0, intr0}, 16'h0);

    // Fill, overflow attempt, drain in order
    for (int i = 1; i <= 4; i++) wr(0, 16'(i), 1'b1);
    rd(0, 1'b1, 16'h13);
    wr(0, 16'h05, 1'b0);
    rd(0, 1'b1, 16'h13);
    for (int i = 1; i <= 4; i++) rd(0, 1'b0, 16'(i));

    // Empty RBR read and non-popping STR reads
    rd(0, 1'b0, 16'h00);
    rd(0, 1'b1, 16'h00);
    wr(0, 16'h11, 1'b1);
    wr(0, 16'h22, 1'b1);
    rd(0, 1'b1, 16'h09);
    rd(0, 1'b1, 16'h09);

    // Pop and push on the same edge at count=2
    fork
      rd(0, 1'b0, 16'h11);
      begin
        repeat (5) @(posedge clock);
        #1;
        wr(0, 16'h33, 1'b1);
      end
    join
    rd(0, 1'b1, 16'h09);
    rd(0, 1'b0, 16'h22);
    rd(0, 1'b0, 16'h33);

    // Pointer wrap over 10 words
    for (int i = 0; i < 3; i++) wr(0, 16'(8'h40 + i), 1'b1);
    for (int i = 3; i < 10; i++) begin
      wr(0, 16'(8'h40 + i), 1'b1);
      rd(0, 1'b0, 16'(8'h40 + i - 3));
    end
    for (int i = 7; i < 10; i++) rd(0, 1'b0, 16'(8'h40 + i));
    rd(0, 1'b1, 16'h00);

    // Reset in the middle of a handshake
    wr(0, 16'h44, 1'b1);
    chk("intr_before_reset", {15'b0, intr0}, 16'h1);
    bin0 = 8'h55; dav_n[0] = 1'b0;
    @(posedge clock); #1;
    reset_ = 1'b0;
    #1;
    chk("async_rst_intr", {15'b0, intr0}, 16'h0);
    chk("async_rst_rfd", {15'b0, rfd0}, 16'h0);
    @(posedge clock); #1;
    dav_n[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_ = 1'b1;
    chk("rfd_low_after_rst", {15'b0, rfd0}, 16'h0);
    @(posedge clock); #1;
    chk("rfd_high_after_rst", {15'b0, rfd0}, 16'h1);
    rd(0, 1'b1, 16'h00);

    // W=16, DEPTH=8 instance
    wr(1, 16'hBEEF, 1'b1);
    for (int i = 1; i < 8; i++) wr(1, 16'(16'h0100 + i), 1'b1);
    rd(1, 1'b1, 16'h0023);
    wr(1, 16'h1234, 1'b0);
    rd(1, 1'b0, 16'hBEEF);
    for (int i = 1; i < 8; i++) rd(1, 1'b0, 16'(16'h0100 + i));
    rd(1, 1'b1, 16'h0000);
    chk("intr16_drained", {15'b0, intr1}, 16'h0);

    repeat (5) @(posedge clock);
    #1;
    chk("scoreboard_drained", 16'(sbq.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
